instr_fetch_unit: RTL and testbench
===================================

# instr_fetch_unit

Sequential instruction fetch front end for the RV32I core: holds the program counter, issues one request at a time to instruction memory over a req/gnt + rvalid handshake, and presents each fetched word with its pre-split opcode/funct3/funct7 fields to the decode/control stage over a valid/ready handshake. It sits between instruction memory and the control unit, producing the fields the control unit consumes. It accepts PC redirects from the branch/jump logic and discards any stale in-flight fetch.

## Interface
Parameters
- RESET_PC, 32'h0000_0000, first fetch address after reset (must be word aligned)

Ports
- clk  in  1  core clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- imem_req  out  1  fetch request valid
- imem_addr  out  32  fetch address, word aligned
- imem_gnt  in  1  memory accepts request this cycle (imem_req & imem_gnt = accept)
- imem_rvalid  in  1  read data valid, at least 1 cycle after accept
- imem_rdata  in  32  instruction word
- redirect_valid  in  1  one-cycle pulse: take redirect_pc
- redirect_pc  in  32  new fetch address
- inst_valid  out  1  instruction available to decode
- inst_ready  in  1  decode consumes instruction (inst_valid & inst_ready = transfer)
- inst  out  32  instruction word
- inst_pc  out  32  address of inst
- opcode  out  7  inst[6:0]
- funct3  out  3  inst[14:12]
- funct7  out  7  inst[31:25]
- fetch_fault  out  1  misaligned redirect flag (ALIGN_CHECK_EN only; else tied 0)

## Operation
- Registers: pc (next fetch address), inst, inst_pc, state, discard flag.
- States: IDLE, REQ, WAIT, HOLD, FAULT (FAULT only with ALIGN_CHECK_EN).
- IDLE: all outputs inactive; unconditionally -> REQ next cycle.
- REQ: imem_req=1, imem_addr=pc. On accept -> WAIT. imem_addr stable while waiting for gnt, except on redirect.
- WAIT: imem_req=0. On imem_rvalid: if discard, drop data, clear discard -> REQ; else capture inst<=imem_rdata, inst_pc<=pc, pc<=pc+4 -> HOLD.
- HOLD: inst_valid=1, inst/fields stable. On transfer -> REQ.
- opcode/funct3/funct7 are pure slices of registered inst.
- pc+4 wraps modulo 2^32 (32'hFFFF_FFFC -> 0).
- Redirect (priority over all other events in the same cycle):
  - IDLE/REQ without accept: pc<=redirect_pc, -> REQ.
  - REQ with accept in same cycle: pc<=redirect_pc, discard<=1, -> WAIT.
  - WAIT: pc<=redirect_pc, discard<=1 (response still awaited and dropped); if imem_rvalid same cycle, data dropped, -> REQ.
  - HOLD: inst_valid drops next cycle, pc<=redirect_pc, -> REQ; a coincident transfer still counts as consumed by decode (decode owns flushing it).
- Only one outstanding memory request ever.

## Timing
- Reset (async assert): state=IDLE, pc=RESET_PC, imem_req=0, imem_addr=RESET_PC, inst_valid=0, inst=0, inst_pc=0, opcode/funct3/funct7=0, discard=0, fetch_fault=0.
- First imem_req: 2nd rising edge after rst_n release (IDLE cycle, then REQ).
- Best-case loop with gnt same cycle, rvalid 1 cycle later, ready held: 1 instruction per 3 cycles (REQ, WAIT, HOLD).
- inst_valid rises the cycle after imem_rvalid is sampled.
- Redirect to new-address imem_req: 1 cycle from IDLE/REQ/HOLD; from WAIT, 1 cycle after stale rvalid.
- Reset mid-operation: immediate return to reset values; any in-flight memory response after release is not expected by the block and memory must be reset together.

## Configuration
- ALIGN_CHECK_EN defined: redirect with redirect_pc[1:0]!=0 -> FAULT (instead of REQ): imem_req=0, inst_valid=0, fetch_fault=1, in-flight response still drained and dropped; stays until an aligned redirect -> REQ, fetch_fault=0 next cycle.
- Not defined: redirect_pc[1:0] forced to 2'b00, no FAULT state, fetch_fault tied 0.

## Test plan
- Reset release, gnt=1, rvalid 1 cycle after accept, ready=1, imem_rdata=32'h00500093 -> imem_addr 0,4,8; inst_valid every 3rd cycle; opcode=7'h13, funct3=0, inst_pc=0 then 4.
- Backpressure: inst_ready=0 for 5 cycles -> inst_valid held, inst/inst_pc stable, imem_req=0 throughout.
- Redirect in WAIT to 32'h100 with rvalid 3 cycles later -> stale word never shown, next imem_addr=32'h100, inst_pc=32'h100.
- Redirect plus accept same cycle -> stale response dropped, next request at redirect_pc.
- pc=32'hFFFF_FFFC fetch -> next imem_addr=0.
- ALIGN_CHECK_EN: redirect_pc=32'h102 -> fetch_fault=1, no requests; then redirect 32'h200 -> fetch_fault=0, imem_addr=32'h200.

Source files
------------

// File: rtl/instr_fetch_unit.sv
// Sequential RV32I fetch front end: one outstanding imem request, valid/ready issue to decode.
// Optional build macro ALIGN_CHECK_EN adds a FAULT state for misaligned redirect targets.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  output logic [6:0]  opcode,
  output logic [2:0]  funct3,
  output logic [6:0]  funct7,
  output logic        fetch_fault
);

  typedef enum logic [2:0] {StIdle, StReq, StWait, StHold, StFault} state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] inst_q, inst_d;
  logic [31:0] inst_pc_q, inst_pc_d;
  logic        discard_q, discard_d;
  logic [31:0] redirect_tgt;
  logic        redirect_bad;
  logic        accept;
  state_e      redirect_state;

`ifdef ALIGN_CHECK_EN
  assign redirect_tgt = redirect_pc;
  assign redirect_bad = |redirect_pc[1:0];
  assign fetch_fault  = (state_q == StFault);
`else
  logic unused_redirect_bits;
  assign unused_redirect_bits = ^redirect_pc[1:0];
  assign redirect_tgt = {redirect_pc[31:2], 2'b00};
  assign redirect_bad = 1'b0;
  assign fetch_fault  = 1'b0;
`endif

  assign imem_req       = (state_q == StReq);
  assign imem_addr      = pc_q;
  assign inst_valid     = (state_q == StHold);
  assign accept         = imem_req & imem_gnt;
  assign redirect_state = redirect_bad ? StFault : StReq;

  assign inst    = inst_q;
  assign inst_pc = inst_pc_q;
  assign opcode  = inst_q[6:0];
  assign funct3  = inst_q[14:12];
  assign funct7  = inst_q[31:25];

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    inst_d    = inst_q;
    inst_pc_d = inst_pc_q;
    discard_d = discard_q;
    unique case (state_q)
      StIdle: begin
        state_d = StReq;
        if (redirect_valid) begin
          pc_d    = redirect_tgt;
          state_d = redirect_state;
        end
      end
      StReq: begin
        if (redirect_valid) begin
          pc_d = redirect_tgt;
          if (accept) begin
            // The accepted request belongs to the old stream; its response must be dropped.
            discard_d = 1'b1;
            state_d   = redirect_bad ? StFault : StWait;
          end else begin
            state_d = redirect_state;
          end
        end else if (accept) begin
          state_d = StWait;
        end
      end
      StWait: begin
        if (redirect_valid) begin
          pc_d      = redirect_tgt;
          discard_d = ~imem_rvalid;
          if (redirect_bad)     state_d = StFault;
          else if (imem_rvalid) state_d = StReq;
        end else if (imem_rvalid) begin
          if (discard_q) begin
            discard_d = 1'b0;
            state_d   = StReq;
          end else begin
            inst_d    = imem_rdata;
            inst_pc_d = pc_q;
            pc_d      = pc_q + 32'd4;
            state_d   = StHold;
          end
        end
      end
      StHold: begin
        if (redirect_valid) begin
          pc_d    = redirect_tgt;
          state_d = redirect_state;
        end else if (inst_ready) begin
          state_d = StReq;
        end
      end
`ifdef ALIGN_CHECK_EN
      StFault: begin
        if (imem_rvalid) discard_d = 1'b0;
        if (redirect_valid) begin
          pc_d = redirect_tgt;
          // Keep a single outstanding request: drain a pending stale response first.
          if (!redirect_bad) state_d = (discard_q && !imem_rvalid) ? StWait : StReq;
        end
      end
`endif
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      pc_q      <= RESET_PC;
      inst_q    <= '0;
      inst_pc_q <= '0;
      discard_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      inst_q    <= inst_d;
      inst_pc_q <= inst_pc_d;
      discard_q <= discard_d;
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: memory and decode are driven cycle by cycle by hand.
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic        fetch_fault;

  int n_checks = 0;
  int n_errors = 0;

  instr_fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_gnt      (imem_gnt),
    .imem_rvalid   (imem_rvalid),
    .imem_rdata    (imem_rdata),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .inst_valid    (inst_valid),
    .inst_ready    (inst_ready),
    .inst          (inst),
    .inst_pc       (inst_pc),
    .opcode        (opcode),
    .funct3        (funct3),
    .funct7        (funct7),
    .fetch_fault   (fetch_fault)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Apply one cycle of inputs, then sample 1ns after the rising edge.
  task automatic tick(input logic g, input logic rv, input logic [31:0] rd, input logic rdy,
                      input logic rr, input logic [31:0] rp);
    imem_gnt       = g;
    imem_rvalid    = rv;
    imem_rdata     = rd;
    inst_ready     = rdy;
    redirect_valid = rr;
    redirect_pc    = rp;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
    inst_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_req", {31'd0, imem_req}, 32'd0);
    check("rst_addr", imem_addr, 32'h0);
    check("rst_valid", {31'd0, inst_valid}, 32'd0);
    check("rst_inst", inst, 32'h0);
    check("rst_inst_pc", inst_pc, 32'h0);
    check("rst_fields", {15'd0, funct7, funct3, opcode}, 32'd0);
    check("rst_fault", {31'd0, fetch_fault}, 32'd0);
    rst_n = 1'b1;

    // IDLE cycle, then REQ at address 0
    tick(0, 0, 0, 0, 0, 0);
    check("first_req", {31'd0, imem_req}, 32'd1);
    check("first_addr", imem_addr, 32'h0);
    tick(1, 0, 0, 0, 0, 0);
    check("wait_req_low", {31'd0, imem_req}, 32'd0);
    tick(0, 1, 32'h0050_0093, 0, 0, 0);
    check("i0_valid", {31'd0, inst_valid}, 32'd1);
    check("i0_inst", inst, 32'h0050_0093);
    check("i0_opcode", {25'd0, opcode}, 32'h13);
    check("i0_funct3", {29'd0, funct3}, 32'd0);
    check("i0_inst_pc", inst_pc, 32'h0);
    tick(0, 0, 0, 1, 0, 0);
    check("i1_addr", imem_addr, 32'h4);
    check("i1_valid_low", {31'd0, inst_valid}, 32'd0);
    tick(1, 0, 0, 0, 0, 0);
    tick(0, 1, 32'h00A0_0113, 0, 0, 0);
    check("i1_inst_pc", inst_pc, 32'h4);
    check("i1_inst", inst, 32'h00A0_0113);

    // Backpressure: held instruction, no requests
    for (int i = 0; i < 5; i++) begin
      tick(0, 0, 0, 0, 0, 0);
      check("bp_valid", {31'd0, inst_valid}, 32'd1);
      check("bp_req", {31'd0, imem_req}, 32'd0);
      check("bp_inst_pc", inst_pc, 32'h4);
      check("bp_inst", inst, 32'h00A0_0113);
    end
    tick(0, 0, 0, 1, 0, 0);
    check("i2_addr", imem_addr, 32'h8);

    // Redirect while waiting; stale response arrives 3 cycles later
    tick(1, 0, 0, 0, 0, 0);
    tick(0, 0, 0, 0, 1, 32'h100);
    check("rw_req_low", {31'd0, imem_req}, 32'd0);
    tick(0, 0, 0, 0, 0, 0);
    tick(0, 0, 0, 0, 0, 0);
    tick(0, 1, 32'hDEAD_BEEF, 0, 0, 0);
    check("rw_stale_hidden", {31'd0, inst_valid}, 32'd0);
    check("rw_req", {31'd0, imem_req}, 32'd1);
    check("rw_addr", imem_addr, 32'h100);
    tick(1, 0, 0, 0, 0, 0);
    tick(0, 1, 32'h0020_8193, 0, 0, 0);
    check("rw_inst_pc", inst_pc, 32'h100);
    check("rw_inst", inst, 32'h0020_8193);

    // Redirect coincident with accept
    tick(0, 0, 0, 1, 0, 0);
    check("ra_addr_old", imem_addr, 32'h104);
    tick(1, 0, 0, 0, 1, 32'h200);
    check("ra_req_low", {31'd0, imem_req}, 32'd0);
    tick(0, 1, 32'hBAD0_BAD0, 0, 0, 0);
    check("ra_stale_hidden", {31'd0, inst_valid}, 32'd0);
    check("ra_addr", imem_addr, 32'h200);
    tick(1, 0, 0, 0, 0, 0);
    tick(0, 1, 32'h4020_8033, 0, 0, 0);
    check("ra_inst_pc", inst_pc, 32'h200);
    check("ra_funct7", {25'd0, funct7}, 32'h20);
    check("ra_opcode", {25'd0, opcode}, 32'h33);

    // Redirect from HOLD to the top word, then wrap
    tick(0, 0, 0, 0, 1, 32'hFFFF_FFFC);
    check("hr_valid_low", {31'd0, inst_valid}, 32'd0);
    check("hr_addr", imem_addr, 32'hFFFF_FFFC);
    tick(1, 0, 0, 0, 0, 0);
    tick(0, 1, 32'h0000_7037, 0, 0, 0);
    check("wrap_inst_pc", inst_pc, 32'hFFFF_FFFC);
    check("wrap_funct3", {29'd0, funct3}, 32'd7);
    tick(0, 0, 0, 1, 0, 0);
    check("wrap_addr", imem_addr, 32'h0);

    // Misaligned redirect target
    tick(0, 0, 0, 0, 1, 32'h102);
`ifdef ALIGN_CHECK_EN
    check("mis_fault", {31'd0, fetch_fault}, 32'd1);
    check("mis_req", {31'd0, imem_req}, 32'd0);
    tick(1, 0, 0, 0, 0, 0);
    check("mis_req_held", {31'd0, imem_req}, 32'd0);
    check("mis_fault_held", {31'd0, fetch_fault}, 32'd1);
    tick(0, 0, 0, 0, 1, 32'h200);
    check("al_fault_clr", {31'd0, fetch_fault}, 32'd0);
    check("al_addr", imem_addr, 32'h200);
`else
    check("mis_forced_addr", imem_addr, 32'h100);
    check("mis_req", {31'd0, imem_req}, 32'd1);
    check("mis_fault_tied", {31'd0, fetch_fault}, 32'd0);
`endif

    // Asynchronous reset mid-operation
    tick(1, 0, 0, 0, 0, 0);
    tick(0, 1, 32'h0050_0093, 0, 0, 0);
    check("pre_rst_valid", {31'd0, inst_valid}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_valid", {31'd0, inst_valid}, 32'd0);
    check("mid_rst_inst", inst, 32'h0);
    check("mid_rst_addr", imem_addr, 32'h0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
